// File: rtl/spi_responder_if.sv
// Signal bundle for spi_responder: SPI pins, host register port and
// commit/error status. The slave modport is the responder's view, the
// master modport is the initiator/host side.
interface spi_responder_if;
    logic       SPI_CLK;
    logic       SPI_CSN;
    logic       SPI_SDI;
    logic       SPI_SDO;
    logic       sdo_oe;
    logic [5:0] host_addr;
    logic       host_we;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       spi_wr_valid;
    logic [5:0] spi_wr_addr;
    logic [7:0] spi_wr_data;
    logic       frame_err;

    modport slave (
        input  SPI_CLK, SPI_CSN, SPI_SDI, host_addr, host_we, host_wdata,
        output SPI_SDO, sdo_oe, host_rdata, spi_wr_valid, spi_wr_addr,
               spi_wr_data, frame_err
    );

    modport master (
        output SPI_CLK, SPI_CSN, SPI_SDI, host_addr, host_we, host_wdata,
        input  SPI_SDO, sdo_oe, host_rdata, spi_wr_valid, spi_wr_addr,
               spi_wr_data, frame_err
    );
endinterface

// File: rtl/spi_responder.sv
// SPI responder (CPOL=1, CPHA=1, 16-bit frames) with a 64 x 8 register file.
// SPI pins are oversampled on clk; a host port gives local register access.
// Optional build macro SPI_RESP_AUTOINC_EN: multi-byte (MB=1) bursts with
// address auto-increment wrapping 63 -> 0.
module spi_responder #(
    parameter logic [7:0]  DEVID          = 8'hE5,
    parameter int unsigned MIN_OVERSAMPLE = 8
) (
    input logic           clk,
    input logic           reset,
    spi_responder_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RDATA,
        ST_WDATA,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;

    logic [1:0]  sclk_sync_q, csn_sync_q, sdi_sync_q;
    logic        sclk_prev_q;
    logic        sclk_s, csn_s, sdi_s;
    logic        rise, fall;

    logic        armed_q;
    logic [4:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  cmd_byte;
    logic [5:0]  addr_q;
    logic [7:0]  tx_q;
    logic        sdo_q, sdo_oe_q;
    logic        wr_valid_q;
    logic [5:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        frame_err_q;
    logic [7:0]  regs_q [64];

    logic        latch_cmd, commit, advance, abort;
    logic        in_frame, host_hit;
    logic        at_boundary, burst;

    logic [7:0]  unused_min_os;
    logic        unused_mb;

`ifdef SPI_RESP_AUTOINC_EN
    logic        mb_q;
    logic        adv_q;
    // CSN may end a burst cleanly only after a complete data byte.
    assign at_boundary = adv_q && (bit_cnt_q == 5'd8);
    assign burst       = mb_q;
`else
    assign at_boundary = 1'b0;
    assign burst       = 1'b0;
`endif

    assign unused_min_os = 8'(MIN_OVERSAMPLE);
    assign unused_mb     = cmd_byte[6];

    assign sclk_s   = sclk_sync_q[1];
    assign csn_s    = csn_sync_q[1];
    assign sdi_s    = sdi_sync_q[1];
    assign rise     = sclk_s & ~sclk_prev_q;
    assign fall     = ~sclk_s & sclk_prev_q;
    assign cmd_byte = {shift_q, sdi_s};
    assign in_frame = (state_q == ST_CMD) || (state_q == ST_RDATA) ||
                      (state_q == ST_WDATA);

    // Two-flop synchronizers for the SPI pins plus SCLK edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '1;
            csn_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.SPI_CLK};
            csn_sync_q  <= {csn_sync_q[0], bus.SPI_CSN};
            sdi_sync_q  <= {sdi_sync_q[0], bus.SPI_SDI};
            sclk_prev_q <= sclk_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-clock control strobes.
    always_comb begin
        state_d   = state_q;
        latch_cmd = 1'b0;
        commit    = 1'b0;
        advance   = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!csn_s && armed_q) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (csn_s) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rise && (bit_cnt_q == 5'd7)) begin
                    latch_cmd = 1'b1;
                    state_d   = cmd_byte[7] ? ST_RDATA : ST_WDATA;
                end
            end
            ST_RDATA, ST_WDATA: begin
                if (csn_s) begin
                    abort   = !at_boundary;
                    state_d = ST_IDLE;
                end else if (rise && (bit_cnt_q == 5'd15)) begin
                    commit = (state_q == ST_WDATA);
                    if (burst) begin
                        advance = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (csn_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame datapath: bit counter, shifters, SDO drive and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            sdo_q       <= 1'b1;
            sdo_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
`ifdef SPI_RESP_AUTOINC_EN
            mb_q        <= 1'b0;
            adv_q       <= 1'b0;
`endif
        end else begin
            // IDLE only accepts a new frame once CSN has been seen high.
            armed_q     <= armed_q | csn_s;
            wr_valid_q  <= commit;
            frame_err_q <= abort;
            if (commit) begin
                wr_addr_q <= addr_q;
                wr_data_q <= cmd_byte;
            end

            if (state_q == ST_IDLE) begin
                bit_cnt_q <= '0;
            end else if (rise && !csn_s && in_frame) begin
                shift_q   <= cmd_byte[6:0];
                bit_cnt_q <= advance ? 5'd8 : bit_cnt_q + 5'd1;
            end

            if (state_d != ST_RDATA) begin
                sdo_q    <= 1'b1;
                sdo_oe_q <= 1'b0;
            end else if (fall && (state_q == ST_RDATA)) begin
                sdo_q    <= tx_q[7];
                tx_q     <= {tx_q[6:0], 1'b0};
                sdo_oe_q <= 1'b1;
            end

            // Snapshot of the read byte; later host writes do not disturb it.
            if (latch_cmd) begin
                addr_q <= cmd_byte[5:0];
                tx_q   <= regs_q[cmd_byte[5:0]];
`ifdef SPI_RESP_AUTOINC_EN
                mb_q   <= cmd_byte[6];
                adv_q  <= 1'b0;
`endif
            end
`ifdef SPI_RESP_AUTOINC_EN
            if (advance) begin
                addr_q <= addr_q + 6'd1;
                tx_q   <= regs_q[addr_q + 6'd1];
                adv_q  <= 1'b1;
            end
`endif
        end
    end

    // SPI write beats a same-address host write in the same clock.
    assign host_hit = bus.host_we && (bus.host_addr != 6'd0) &&
                      !(commit && (bus.host_addr == addr_q));

    // Register file; address 0 is the read-only device ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 64; i++) begin
                regs_q[i] <= (i == 0) ? DEVID : '0;
            end
        end else begin
            if (host_hit) begin
                regs_q[bus.host_addr] <= bus.host_wdata;
            end
            if (commit && (addr_q != 6'd0)) begin
                regs_q[addr_q] <= cmd_byte;
            end
        end
    end

    assign bus.host_rdata   = regs_q[bus.host_addr];
    assign bus.SPI_SDO      = sdo_q;
    assign bus.sdo_oe       = sdo_oe_q;
    assign bus.spi_wr_valid = wr_valid_q;
    assign bus.spi_wr_addr  = wr_addr_q;
    assign bus.spi_wr_data  = wr_data_q;
    assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed frames from the test plan
// followed by randomized host/SPI traffic against an array register model.
module tb_spi_responder;

    localparam int unsigned MIN_OVERSAMPLE = 8;
    localparam int unsigned HALF           = 8;   // clk per SCLK half period

    logic clk;
    logic reset;

    spi_responder_if bus ();

    spi_responder #(
        .DEVID          (8'hE5),
        .MIN_OVERSAMPLE (MIN_OVERSAMPLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] mdl [64];
    int         wr_cnt   = 0;
    int         ferr_cnt = 0;
    logic [5:0] last_wa;
    logic [7:0] last_wd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Status pulse observers.
    always @(negedge clk) begin
        if (!reset && bus.spi_wr_valid === 1'b1) begin
            wr_cnt++;
            last_wa = bus.spi_wr_addr;
            last_wd = bus.spi_wr_data;
        end
        if (!reset && bus.frame_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(input logic [5:0] a, input logic [7:0] d);
        if (a != 6'd0) mdl[a] = d;
    endfunction

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        @(negedge clk);
        bus.host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [5:0] a, output logic [7:0] d);
        bus.host_addr = a;
        #1;
        d = bus.host_rdata;
    endtask

    // One SPI transaction of nbits SCLK cycles, MOSI left-aligned in mosi.
    // Optionally a host write is placed in the clock of the last-bit commit.
    task automatic spi_frame(input logic [31:0] mosi, input int nbits,
                             input bit hc, input logic [5:0] hc_a,
                             input logic [7:0] hc_d,
                             output logic [31:0] miso, output int oe_bad);
        logic [31:0] m;
        m      = mosi;
        miso   = '0;
        oe_bad = 0;
        @(negedge clk);
        bus.SPI_CSN = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.SPI_CLK = 1'b0;
            bus.SPI_SDI = m[31];
            m = m << 1;
            repeat (HALF) @(negedge clk);
            miso = {miso[30:0], bus.SPI_SDO};
            if (i >= 8 && i < 16 && bus.sdo_oe !== 1'b1) oe_bad++;
            if (i < 8 && bus.sdo_oe !== 1'b0) oe_bad++;
            bus.SPI_CLK = 1'b1;
            if (hc && i == nbits - 1) begin
                @(negedge clk);
                @(negedge clk);
                bus.host_addr  = hc_a;
                bus.host_wdata = hc_d;
                bus.host_we    = 1'b1;
                @(negedge clk);
                bus.host_we    = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        bus.SPI_CSN = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    initial begin
        logic [31:0] miso;
        logic [7:0]  rd;
        int          oe_bad;
        int          w0, f0;
        logic [5:0]  a;
        logic [7:0]  d;
        bit          mb;

        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
        mdl[0] = 8'hE5;

        bus.SPI_CLK    = 1'b1;
        bus.SPI_CSN    = 1'b1;
        bus.SPI_SDI    = 1'b0;
        bus.host_addr  = '0;
        bus.host_we    = 1'b0;
        bus.host_wdata = '0;
        reset          = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_sdo", bus.SPI_SDO, 1);
        check("rst_oe", bus.sdo_oe, 0);
        check("rst_wr_valid", bus.spi_wr_valid, 0);
        check("rst_wr_addr", bus.spi_wr_addr, 0);
        check("rst_wr_data", bus.spi_wr_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        host_read(6'd0, rd);  check("rst_reg0", rd, 8'hE5);
        host_read(6'd5, rd);  check("rst_reg5", rd, 8'h00);

        // Read DEVID.
        w0 = wr_cnt;
        spi_frame(32'h8000_0000, 16, 0, '0, '0, miso, oe_bad);
        check("devid_sdo", miso[7:0], 8'hE5);
        check("devid_oe", oe_bad, 0);
        check("devid_no_wr", wr_cnt - w0, 0);

        // Write then read back.
        w0 = wr_cnt;
        spi_frame(32'h0A5C_0000, 16, 0, '0, '0, miso, oe_bad);
        model_write(6'h0A, 8'h5C);
        check("wr_pulses", wr_cnt - w0, 1);
        check("wr_addr", last_wa, 6'h0A);
        check("wr_data", last_wd, 8'h5C);
        host_read(6'h0A, rd);  check("wr_host_rd", rd, mdl[6'h0A]);
        spi_frame(32'h8A00_0000, 16, 0, '0, '0, miso, oe_bad);
        check("wr_spi_rd", miso[7:0], mdl[6'h0A]);

        // Write to read-only address 0.
        w0 = wr_cnt;
        spi_frame(32'h0012_0000, 16, 0, '0, '0, miso, oe_bad);
        model_write(6'h00, 8'h12);
        check("ro_pulses", wr_cnt - w0, 1);
        check("ro_addr", last_wa, 6'h00);
        check("ro_data", last_wd, 8'h12);
        host_read(6'h00, rd);  check("ro_host_rd", rd, mdl[0]);
        spi_frame(32'h8000_0000, 16, 0, '0, '0, miso, oe_bad);
        check("ro_spi_rd", miso[7:0], 8'hE5);
        host_write(6'h00, 8'h77);
        host_read(6'h00, rd);  check("ro_host_wr", rd, 8'hE5);

        // Abort after 11 bits.
        w0 = wr_cnt; f0 = ferr_cnt;
        spi_frame(32'h0333_0000, 11, 0, '0, '0, miso, oe_bad);
        check("abort_ferr", ferr_cnt - f0, 1);
        check("abort_no_wr", wr_cnt - w0, 0);
        host_read(6'h03, rd);  check("abort_reg3", rd, mdl[3]);
        spi_frame(32'h0396_0000, 16, 0, '0, '0, miso, oe_bad);
        model_write(6'h03, 8'h96);
        spi_frame(32'h8300_0000, 16, 0, '0, '0, miso, oe_bad);
        check("abort_after_rd", miso[7:0], mdl[3]);
        check("abort_after_ferr", ferr_cnt - f0, 1);

        // Collisions with a host write in the SPI commit clock.
        spi_frame(32'h0555_0000, 16, 1, 6'h05, 8'hAA, miso, oe_bad);
        model_write(6'h05, 8'h55);
        host_read(6'h05, rd);  check("coll_same", rd, mdl[5]);
        spi_frame(32'h0555_0000, 16, 1, 6'h06, 8'hAA, miso, oe_bad);
        model_write(6'h05, 8'h55);
        model_write(6'h06, 8'hAA);
        host_read(6'h06, rd);  check("coll_diff_host", rd, mdl[6]);
        host_read(6'h05, rd);  check("coll_diff_spi", rd, mdl[5]);

`ifdef SPI_RESP_AUTOINC_EN
        // Burst read across the 63 -> 0 wrap.
        host_write(6'h3E, 8'h11);  model_write(6'h3E, 8'h11);
        host_write(6'h3F, 8'h22);  model_write(6'h3F, 8'h22);
        f0 = ferr_cnt;
        spi_frame(32'hFE00_0000, 32, 0, '0, '0, miso, oe_bad);
        check("ai_byte0", miso[23:16], mdl[6'h3E]);
        check("ai_byte1", miso[15:8], mdl[6'h3F]);
        check("ai_wrap", miso[7:0], mdl[6'h00]);
        check("ai_no_ferr", ferr_cnt - f0, 0);
`else
        // Extra SCLKs after a complete frame are ignored.
        f0 = ferr_cnt;
        spi_frame(32'hC500_0000, 24, 0, '0, '0, miso, oe_bad);
        check("extra_data", miso[15:8], mdl[5]);
        check("extra_sdo_idle", miso[7:0], 8'hFF);
        check("extra_no_ferr", ferr_cnt - f0, 0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 30; n++) begin
            a  = 6'($urandom_range(0, 63));
            d  = 8'($urandom);
            mb = 1'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    host_write(a, d);
                    model_write(a, d);
                    host_read(a, rd);
                    check($sformatf("rnd_host_%0d", n), rd, mdl[a]);
                end
                1: begin
                    w0 = wr_cnt;
                    spi_frame({1'b0, mb, a, d, 16'h0}, 16, 0, '0, '0, miso, oe_bad);
                    model_write(a, d);
                    check($sformatf("rnd_wrcnt_%0d", n), wr_cnt - w0, 1);
                    check($sformatf("rnd_wraddr_%0d", n), last_wa, a);
                    check($sformatf("rnd_wrdata_%0d", n), last_wd, d);
                    host_read(a, rd);
                    check($sformatf("rnd_wrback_%0d", n), rd, mdl[a]);
                end
                default: begin
                    spi_frame({1'b1, mb, a, 8'h00, 16'h0}, 16, 0, '0, '0, miso, oe_bad);
                    check($sformatf("rnd_rd_%0d", n), miso[7:0], mdl[a]);
                    check($sformatf("rnd_oe_%0d", n), oe_bad, 0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
